// File: rtl/systolic_drain.sv
// Drains a ROWS x COLS systolic accumulator array into a result buffer, one row per accepted write.
// Optional post-drain PE clear strobe is built when DRAIN_CLEAR_EN is defined.
module systolic_drain #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ROWS*COLS*32-1:0]  acc_flat,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [COLS*32-1:0]       wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     pe_clear
);

  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROW_BITS = COLS * 32;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} state_t;

  state_t                           state;
  logic [ROWS-1:0][ROW_BITS-1:0]    snap;
  logic [ROW_W-1:0]                 row;
  logic [ADDR_W-1:0]                base_q;
  logic                             last_row;

  assign last_row = (row == ROW_W'(ROWS - 1));

  // Address and data are pure decodes of frozen state, so they stay stable across stalls.
  assign wr_addr = base_q + ADDR_W'(row);
  assign wr_data = snap[row];

`ifdef DRAIN_CLEAR_EN
  logic pe_clear_q;
  assign pe_clear = pe_clear_q;
`else
  assign pe_clear = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      snap   <= '0;
      row    <= '0;
      base_q <= '0;
      wr_en  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef DRAIN_CLEAR_EN
      pe_clear_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap   <= acc_flat;
            base_q <= base_addr;
            row    <= '0;
            wr_en  <= 1'b1;
            busy   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (last_row) begin
              wr_en <= 1'b0;
`ifdef DRAIN_CLEAR_EN
              pe_clear_q <= 1'b1;
              state      <= CLEAR;
`else
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        CLEAR: begin
`ifdef DRAIN_CLEAR_EN
          pe_clear_q <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized self-checking bench for systolic_drain against a row-list reference model.
module tb_systolic_drain;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ADDR_W = 12;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [ROWS*COLS*32-1:0] acc_flat;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [COLS*32-1:0]      wr_data;
  logic                    wr_ready;
  logic                    busy;
  logic                    done;
  logic                    pe_clear;

  logic [31:0] acc [ROWS][COLS];
  int nchk = 0;
  int npass = 0;

  systolic_drain #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .acc_flat(acc_flat), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .pe_clear(pe_clear)
  );

  always #5 clk = ~clk;

  task automatic drive_acc();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        acc_flat[(r*COLS+c)*32 +: 32] = acc[r][c];
  endtask

  // One complete drain: the model is the list of rows captured at start,
  // each written to (base + row) mod 2^ADDR_W, followed by optional clear and done.
  task automatic do_drain(input logic [ADDR_W-1:0] base, input int stall_mode, input bit glitch);
    logic [COLS*32-1:0] exp_rows [ROWS];
    logic [COLS*32-1:0] erow;
    logic [ADDR_W-1:0]  ea;
    int stalls;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_rows[r][c*32 +: 32] = acc[r][c];
    @(negedge clk);
    start = 1'b1; base_addr = base; wr_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      stalls = (stall_mode == 0) ? 0 : (stall_mode == 1) ? ((r == 1) ? 3 : 0) : int'($urandom_range(0, 2));
      erow = exp_rows[r];
      ea = ADDR_W'(base + r);
      for (int s = 0; s <= stalls; s++) begin
        @(negedge clk);
        start = glitch && r == 0 && s == 0;
        if (start) begin
          for (int rr = 0; rr < ROWS; rr++)
            for (int c = 0; c < COLS; c++) acc[rr][c] = $urandom;
          drive_acc();
          base_addr = ~base;
        end
        nchk++;
        if (wr_en !== 1'b1 || wr_addr !== ea || busy !== 1'b1 || done !== 1'b0 || pe_clear !== 1'b0)
          $display("FAIL write_ctl row %0d cyc %0d: wr_en=%b addr=%h busy=%b done=%b clr=%b, want 1 %h 1 0 0",
                   r, s, wr_en, wr_addr, busy, done, pe_clear, ea);
        else npass++;
        nchk++;
        if (wr_data !== erow)
          $display("FAIL write_data row %0d cyc %0d: got %h want %h", r, s, wr_data, erow);
        else npass++;
        wr_ready = (s == stalls);
      end
    end
`ifdef DRAIN_CLEAR_EN
    @(negedge clk);
    start = 1'b0; wr_ready = 1'($urandom);
    nchk++;
    if (pe_clear !== 1'b1 || wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
      $display("FAIL clear_cycle: clr=%b wr_en=%b done=%b busy=%b, want 1 0 0 1", pe_clear, wr_en, done, busy);
    else npass++;
`endif
    @(negedge clk);
    start = 1'b0; wr_ready = 1'($urandom);
    nchk++;
    if (done !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0 || pe_clear !== 1'b0)
      $display("FAIL done_cycle: done=%b busy=%b wr_en=%b clr=%b, want 1 1 0 0", done, busy, wr_en, pe_clear);
    else npass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || pe_clear !== 1'b0)
        $display("FAIL idle_after %0d: done=%b busy=%b wr_en=%b clr=%b, want 0 0 0 0", i, done, busy, wr_en, pe_clear);
      else npass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; wr_ready = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) acc[r][c] = $urandom;
    drive_acc();
    repeat (2) @(negedge clk);
    nchk++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pe_clear !== 1'b0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL reset_vals: wr_en=%b busy=%b done=%b clr=%b addr=%h data=%h, want all 0",
               wr_en, busy, done, pe_clear, wr_addr, wr_data);
    else npass++;
    rst_n = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pe_clear !== 1'b0)
        $display("FAIL post_reset_quiet %0d: wr_en=%b busy=%b done=%b clr=%b, want 0", i, wr_en, busy, done, pe_clear);
      else npass++;
    end
  endtask

  task automatic test_basic();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) acc[r][c] = r * 16 + c;
    drive_acc();
    do_drain(12'h100, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_drain(12'h100, 1, 1'b0);
  endtask

  task automatic test_wrap();
    do_drain(12'hFFE, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    do_drain(12'h2A0, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    start = 1'b1; base_addr = 12'h300; wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    ea = 12'h302;
    nchk++;
    if (wr_en !== 1'b1 || wr_addr !== ea)
      $display("FAIL mid_reset_row2: wr_en=%b addr=%h, want 1 %h", wr_en, wr_addr, ea);
    else npass++;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset: wr_en=%b busy=%b done=%b, want 0 0 0", wr_en, busy, done);
    else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (wr_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_release_quiet: wr_en=%b busy=%b, want 0 0", wr_en, busy);
    else npass++;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) acc[r][c] = $urandom;
    drive_acc();
    do_drain(12'h300, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) acc[r][c] = $urandom;
      drive_acc();
      do_drain(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter ROWS, default 4, number of PE rows drained.
REQ-002 Parameter COLS, default 4, number of PE columns per row.
REQ-003 Parameter ADDR_W, default 12, result-buffer address width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  single-cycle request to drain the array; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  buffer address for row 0; sampled with start.
REQ-008 acc_flat  input  ROWS*COLS*32  PE accumulators; PE(r,c) occupies bits [(r*COLS+c)*32 +: 32].
REQ-009 wr_en  output  1  row write valid.
REQ-010 wr_addr  output  ADDR_W  row write address.
REQ-011 wr_data  output  COLS*32  row data; column c at bits [c*32 +: 32].
REQ-012 wr_ready  input  1  buffer accepts the write in the current cycle.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 pe_clear  output  1  clear strobe to the PE array.

Function
REQ-016 FSM states: IDLE, WRITE, CLEAR, DONE; DONE returns to IDLE unconditionally after one cycle.
REQ-017 IDLE with start=1: on that edge, capture all of acc_flat into an internal snapshot, latch base_addr, clear row counter to 0, go to WRITE.
REQ-018 Snapshot is frozen from capture until IDLE; later acc_flat changes do not affect wr_data.
REQ-019 WRITE: wr_en=1; wr_data = snapshot row[row counter]; wr_addr = latched base_addr + row counter, modulo 2^ADDR_W.
REQ-020 A row is accepted on an edge where wr_en=1 and wr_ready=1; only then does the row counter advance.
REQ-021 While wr_ready=0, wr_en, wr_addr and wr_data hold stable.
REQ-022 Acceptance of row ROWS-1 exits WRITE (to CLEAR or DONE per REQ-031/032); the row counter is never observed at ROWS.
REQ-023 done=1 only in DONE; wr_en=0 in every state except WRITE.
REQ-024 start while busy=1 is ignored; no queuing, no restart.
REQ-025 First wr_en is the cycle after start; with wr_ready held high, a drain takes ROWS write cycles plus 1 (CLEAR, if enabled) plus 1 (DONE).
REQ-026 Data pass through unmodified; no sign extension, offset or saturation.

Reset
REQ-027 rst_n=0 forces IDLE immediately, including mid-drain; any partially drained row is discarded.
REQ-028 Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, pe_clear=0; snapshot, row counter and latched address = 0.
REQ-029 After reset release, no output activity occurs until a new start.

Configuration
REQ-030 Macro DRAIN_CLEAR_EN selects post-drain array clearing.
REQ-031 DRAIN_CLEAR_EN defined: after the last row is accepted, enter CLEAR for exactly one cycle with pe_clear=1, then DONE.
REQ-032 DRAIN_CLEAR_EN undefined: CLEAR state is unreachable, pe_clear is constant 0, and the last acceptance goes directly to DONE.

Verification
REQ-033 acc_flat PE(r,c)=r*16+c, base_addr=0x100, wr_ready=1, start pulse -> writes at 0x100..0x103 on consecutive cycles; row 2 wr_data cols = 0x20,0x21,0x22,0x23; done pulses once; busy spans the whole drain.
REQ-034 Same drain with wr_ready low for 3 cycles during row 1 -> wr_addr=0x101 and its data are held stable for all 4 cycles; exactly 4 accepted writes in total.
REQ-035 base_addr=0xFFE, ADDR_W=12 -> wr_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
REQ-036 acc_flat changed and a second start pulsed on the cycle after start -> written data equal the original snapshot; only one done pulse.
REQ-037 rst_n asserted while row 2 is presented -> wr_en, busy and done are 0 immediately; a fresh start after release drains all rows from row 0.
REQ-038 DRAIN_CLEAR_EN defined -> pe_clear=1 for exactly one cycle between the last accepted write and done; undefined -> pe_clear is never 1 and done follows the last accept by one cycle.
